// File: rtl/tr_pkg.sv
// Shared constants and state encoding for the step/dir pulse generator and its monitor.
// The period width is common to both sides so a measured period compares directly with N.
package tr_pkg;
    localparam int PER_W          = 17;
    localparam int MIN_PERIOD_DEF = 16;
    localparam int TIMEOUT_DEF    = (1 << PER_W) - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIRST,
        ST_RUN,
        ST_STALL
    } tr_state_t;
endpackage

// File: rtl/sync_edge.sv
// 2-flop synchronizer plus history flop; rise/fall valid 2 clocks after the input moves.
// Edges are suppressed until a genuine low has been seen after reset. No backpressure.
module sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_lvl,
    output logic o_rise,
    output logic o_fall
);
    logic r_s1, r_s2, r_s3;
    logic r_v1, r_v2, r_armed;

    // r_v2 marks that r_s2 holds a real sample rather than a reset value
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_s3    <= 1'b0;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_s1    <= i_async;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_v1    <= 1'b1;
            r_v2    <= r_v1;
            r_armed <= r_armed | (r_v2 & ~r_s2);
        end
    end

    assign o_lvl  = r_s2;
    assign o_rise = r_armed & r_s2 & ~r_s3;
    assign o_fall = r_armed & ~r_s2 & r_s3;
endmodule

// File: rtl/step_dir_monitor.sv
// Step/dir receiver: signed position, step period in clocks, sticky protocol error flags.
// Outputs update 3 clocks after the first sampling edge of a step rise; no backpressure.
module step_dir_monitor #(
    parameter int POS_W      = 32,
    parameter int PER_W      = tr_pkg::PER_W,
    parameter int MIN_PERIOD = tr_pkg::MIN_PERIOD_DEF,
    parameter int MIN_HIGH   = 2,
    parameter int DIR_SETUP  = 2,
    parameter int TIMEOUT    = tr_pkg::TIMEOUT_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_drv_step,
    input  logic             i_drv_dir,
    input  logic             i_drv_enable_SM,
    input  logic             i_pos_clr,
    input  logic             i_err_clr,
    output logic [POS_W-1:0] o_position,
    output logic [PER_W-1:0] o_period,
    output logic             o_period_vld,
    output logic             o_step_seen,
    output logic             o_stalled,
    output logic             o_err_overspeed,
    output logic             o_err_width,
    output logic             o_err_dir
);
    import tr_pkg::*;

    localparam int HI_W = $clog2(MIN_HIGH + 1);
    localparam int DS_W = $clog2(DIR_SETUP + 1);
    localparam logic [PER_W-1:0] CNT_MAX = '1;
    localparam logic [PER_W-1:0] TO_V    = PER_W'(TIMEOUT);
    localparam logic [PER_W-1:0] MINP_V  = PER_W'(MIN_PERIOD);
    localparam logic [HI_W-1:0]  MINH_V  = HI_W'(MIN_HIGH);
    localparam logic [DS_W-1:0]  DS_V    = DS_W'(DIR_SETUP);

    logic w_step_lvl, w_step_rise, w_step_fall;
    logic w_dir_lvl, w_dir_rise, w_dir_fall;

    sync_edge u_step_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_drv_step),
        .o_lvl   (w_step_lvl),
        .o_rise  (w_step_rise),
        .o_fall  (w_step_fall)
    );

    sync_edge u_dir_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_drv_dir),
        .o_lvl   (w_dir_lvl),
        .o_rise  (w_dir_rise),
        .o_fall  (w_dir_fall)
    );

    logic [HI_W-1:0] r_high_cnt;
    logic [DS_W-1:0] r_dir_age;
    logic [DS_W-1:0] w_dir_age;
    logic            r_edge_p, r_dir_p, r_dir_bad_p, r_width_bad_p;

    assign w_dir_age = (w_dir_rise | w_dir_fall) ? '0 : r_dir_age;

    // Edge qualification stage: every event is judged here and acted on one clock later
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_high_cnt    <= '0;
            r_dir_age     <= DS_V;
            r_edge_p      <= 1'b0;
            r_dir_p       <= 1'b0;
            r_dir_bad_p   <= 1'b0;
            r_width_bad_p <= 1'b0;
        end else begin
            if (!w_step_lvl)
                r_high_cnt <= '0;
            else if (r_high_cnt != MINH_V)
                r_high_cnt <= r_high_cnt + HI_W'(1);
            r_dir_age     <= (w_dir_age == DS_V) ? DS_V : w_dir_age + DS_W'(1);
            r_edge_p      <= w_step_rise;
            r_dir_p       <= w_dir_lvl;
            r_dir_bad_p   <= w_step_rise & (w_dir_age < DS_V);
            r_width_bad_p <= w_step_fall & (r_high_cnt < MINH_V);
        end
    end

    tr_state_t        r_state, w_state_nxt;
    logic [PER_W-1:0] r_cnt;
    logic             w_to, w_accept, w_measure;
    logic             w_set_ovs, w_set_wid, w_set_dir;

    assign w_to = (r_cnt == TO_V);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_measure   = 1'b0;
        if (!i_drv_enable_SM) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_FIRST;
                ST_FIRST, ST_RUN: begin
                    if (r_edge_p) begin
                        w_accept    = 1'b1;
                        w_measure   = (r_state == ST_RUN);
                        w_state_nxt = ST_RUN;
                    end else if (w_to) begin
                        w_state_nxt = ST_STALL;
                    end
                end
                ST_STALL: begin
                    if (r_edge_p) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_RUN;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_set_ovs = w_measure & (r_cnt < MINP_V);
        w_set_dir = w_accept & r_dir_bad_p;
        w_set_wid = r_width_bad_p & (r_state != ST_IDLE);
    end

    logic [POS_W-1:0] r_pos;
    logic [PER_W-1:0] r_period;
    logic             r_period_vld, r_step_seen;
    logic             r_err_ovs, r_err_wid, r_err_dir;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt        <= '0;
            r_pos        <= '0;
            r_period     <= '0;
            r_period_vld <= 1'b0;
            r_step_seen  <= 1'b0;
            r_err_ovs    <= 1'b0;
            r_err_wid    <= 1'b0;
            r_err_dir    <= 1'b0;
        end else begin
            r_step_seen <= w_accept;

            if (!i_drv_enable_SM || r_state == ST_IDLE)
                r_cnt <= '0;
            else if (w_accept)
                r_cnt <= PER_W'(1);
            else if (r_cnt != CNT_MAX)
                r_cnt <= r_cnt + PER_W'(1);

            // a coincident clear drops the step from the count
            if (i_pos_clr)
                r_pos <= '0;
            else if (w_accept)
                r_pos <= r_dir_p ? r_pos + POS_W'(1) : r_pos - POS_W'(1);

            if (w_measure)
                r_period <= r_cnt;

            if (!i_drv_enable_SM)
                r_period_vld <= 1'b0;
            else if (w_measure)
                r_period_vld <= 1'b1;
            else if (w_state_nxt == ST_STALL && r_state != ST_STALL)
                r_period_vld <= 1'b0;

            r_err_ovs <= (r_err_ovs & ~i_err_clr) | w_set_ovs;
            r_err_wid <= (r_err_wid & ~i_err_clr) | w_set_wid;
            r_err_dir <= (r_err_dir & ~i_err_clr) | w_set_dir;
        end
    end

    assign o_position      = r_pos;
    assign o_period        = r_period;
    assign o_period_vld    = r_period_vld;
    assign o_step_seen     = r_step_seen;
    assign o_stalled       = (r_state == ST_STALL);
    assign o_err_overspeed = r_err_ovs;
    assign o_err_width     = r_err_wid;
    assign o_err_dir       = r_err_dir;
endmodule

// File: tb/tb_step_dir_monitor.sv
// Bench for step_dir_monitor: step events scored against a queue of expected results,
// sticky flags, stall and reset behaviour checked directly.
module tb_step_dir_monitor;
    localparam int POS_W      = 32;
    localparam int PER_W      = 17;
    localparam int MIN_PERIOD = 16;
    localparam int MIN_HIGH   = 2;
    localparam int DIR_SETUP  = 2;
    localparam int TIMEOUT    = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             i_rst, i_drv_step, i_drv_dir, i_drv_enable_SM, i_pos_clr, i_err_clr;
    logic [POS_W-1:0] o_position;
    logic [PER_W-1:0] o_period;
    logic             o_period_vld, o_step_seen, o_stalled;
    logic             o_err_overspeed, o_err_width, o_err_dir;

    step_dir_monitor #(
        .POS_W      (POS_W),
        .PER_W      (PER_W),
        .MIN_PERIOD (MIN_PERIOD),
        .MIN_HIGH   (MIN_HIGH),
        .DIR_SETUP  (DIR_SETUP),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .i_clk           (clk),
        .i_rst           (i_rst),
        .i_drv_step      (i_drv_step),
        .i_drv_dir       (i_drv_dir),
        .i_drv_enable_SM (i_drv_enable_SM),
        .i_pos_clr       (i_pos_clr),
        .i_err_clr       (i_err_clr),
        .o_position      (o_position),
        .o_period        (o_period),
        .o_period_vld    (o_period_vld),
        .o_step_seen     (o_step_seen),
        .o_stalled       (o_stalled),
        .o_err_overspeed (o_err_overspeed),
        .o_err_width     (o_err_width),
        .o_err_dir       (o_err_dir)
    );

    typedef struct packed {
        logic [POS_W-1:0] pos;
        logic [PER_W-1:0] per;
        logic             vld;
        logic             ovs;
        logic             dir_e;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // reference model state
    logic [POS_W-1:0] m_pos;
    logic [PER_W-1:0] m_per;
    bit               m_vld, m_ovs, m_dir_e, m_wid, m_ref, m_en;
    int               m_last_rise, m_dir_chg;
    int               r_last;

    task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pos = '0; m_per = '0; m_vld = 0; m_ovs = 0; m_dir_e = 0; m_wid = 0; m_ref = 0;
    endtask

    task automatic set_dir(input bit d);
        if (d != i_drv_dir) m_dir_chg = cyc;
        i_drv_dir = d;
    endtask

    task automatic set_en(input bit e);
        i_drv_enable_SM = e;
        m_en = e;
        if (!e) begin
            m_ref = 0;
            m_vld = 0;
        end
    endtask

    task automatic clr_err();
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        m_ovs = 0; m_dir_e = 0; m_wid = 0;
    endtask

    // one step pulse; clr/ec assert pos_clr/err_clr on the cycle the edge is processed
    task automatic pulse(input int hi, input int lo, input bit clr, input bit ec);
        int   gap;
        exp_t e;
        i_drv_step = 1'b1;
        if (m_en) begin
            gap = cyc - m_last_rise;
            if (ec) begin
                m_ovs = 0; m_dir_e = 0; m_wid = 0;
            end
            if (m_ref && gap <= TIMEOUT) begin
                m_per = PER_W'(gap);
                m_vld = 1;
                if (gap < MIN_PERIOD) m_ovs = 1;
            end else begin
                m_vld = 0;
            end
            if (cyc - m_dir_chg < DIR_SETUP) m_dir_e = 1;
            m_pos = clr ? '0 : (i_drv_dir ? m_pos + 1 : m_pos - 1);
            m_ref = 1;
            m_last_rise = cyc;
            e.pos = m_pos; e.per = m_per; e.vld = m_vld; e.ovs = m_ovs; e.dir_e = m_dir_e;
            sb_q.push_back(e);
            if (hi < MIN_HIGH) m_wid = 1;
        end
        for (int i = 0; i < hi; i++) begin
            i_pos_clr = clr && (i == 3);
            i_err_clr = ec && (i == 3);
            tick();
        end
        i_pos_clr  = 1'b0;
        i_err_clr  = 1'b0;
        i_drv_step = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk_val({pfx, "_position"}, o_position, 0);
        chk_val({pfx, "_period"}, o_period, 0);
        chk_val({pfx, "_period_vld"}, o_period_vld, 0);
        chk_val({pfx, "_step_seen"}, o_step_seen, 0);
        chk_val({pfx, "_stalled"}, o_stalled, 0);
        chk_val({pfx, "_err_overspeed"}, o_err_overspeed, 0);
        chk_val({pfx, "_err_width"}, o_err_width, 0);
        chk_val({pfx, "_err_dir"}, o_err_dir, 0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (o_step_seen) begin
            if (sb_q.size() == 0) begin
                chk_val("step_unexpected", o_step_seen, 0);
            end else begin
                e = sb_q.pop_front();
                chk_val("sb_position", o_position, e.pos);
                chk_val("sb_period", o_period, e.per);
                chk_val("sb_period_vld", o_period_vld, e.vld);
                chk_val("sb_err_overspeed", o_err_overspeed, e.ovs);
                chk_val("sb_err_dir", o_err_dir, e.dir_e);
                chk_val("sb_stalled", o_stalled, 0);
            end
        end
    end

    initial begin
        i_rst = 1'b1; i_drv_step = 1'b0; i_drv_dir = 1'b1; i_drv_enable_SM = 1'b0;
        i_pos_clr = 1'b0; i_err_clr = 1'b0;
        m_en = 0; m_last_rise = -1000; m_dir_chg = -1000;
        model_reset();
        repeat (3) tick();
        chk_reset_outputs("rst");
        i_rst = 1'b0;
        set_en(1);
        repeat (5) tick();

        // ten forward steps, period 20, high 4
        for (int i = 0; i < 10; i++) pulse(4, 16, 0, 0);
        chk_val("fwd_position", o_position, 10);
        chk_val("fwd_period", o_period, 20);
        chk_val("fwd_period_vld", o_period_vld, 1);
        chk_val("fwd_err_overspeed", o_err_overspeed, 0);

        // reverse, then a position clear coincident with the 6th edge
        set_dir(0);
        repeat (4) tick();
        for (int i = 0; i < 5; i++) pulse(4, 16, 0, 0);
        chk_val("rev_position", o_position, 5);
        pulse(4, 16, 1, 0);
        chk_val("posclr_position", o_position, 0);

        // overspeed at period 10
        set_dir(1);
        repeat (4) tick();
        for (int i = 0; i < 4; i++) pulse(4, 6, 0, 0);
        chk_val("ovs_set", o_err_overspeed, 1);
        clr_err();
        chk_val("ovs_cleared", o_err_overspeed, 0);
        pulse(4, 6, 0, 1);
        chk_val("ovs_set_beats_clr", o_err_overspeed, 1);
        clr_err();
        repeat (10) tick();
        chk_val("ovs_cleared2", o_err_overspeed, 0);

        // short pulse and late direction change
        pulse(4, 16, 0, 0);
        pulse(1, 19, 0, 0);
        chk_val("width_set", o_err_width, 1);
        chk_val("width_dir_clean", o_err_dir, 0);
        set_dir(0);
        tick();
        pulse(4, 16, 0, 0);
        chk_val("dir_set", o_err_dir, 1);
        clr_err();
        chk_val("errclr_width", o_err_width, 0);
        chk_val("errclr_dir", o_err_dir, 0);
        repeat (4) tick();

        // stall after the last edge
        pulse(4, 16, 0, 0);
        r_last = cyc;
        pulse(4, 10, 0, 0);
        while (cyc < r_last + 103) tick();
        chk_val("stall_not_yet", o_stalled, 0);
        tick();
        chk_val("stall_set", o_stalled, 1);
        chk_val("stall_vld_low", o_period_vld, 0);
        pulse(4, 16, 0, 0);
        chk_val("stall_cleared", o_stalled, 0);
        pulse(4, 16, 0, 0);
        chk_val("post_stall_vld", o_period_vld, 1);

        // disable mid-train: edges ignored
        set_en(0);
        tick();
        chk_val("dis_vld", o_period_vld, 0);
        chk_val("dis_stalled", o_stalled, 0);
        pulse(4, 16, 0, 0);
        pulse(4, 16, 0, 0);
        chk_val("dis_position", o_position, m_pos);
        set_en(1);
        repeat (3) tick();
        pulse(4, 16, 0, 0);
        set_dir(1);
        tick();
        pulse(4, 16, 0, 0);
        chk_val("reen_err_dir", o_err_dir, 1);

        // reset in the middle of a pulse; the held-high step must not count
        i_drv_step = 1'b1;
        repeat (2) tick();
        i_rst = 1'b1;
        tick();
        model_reset();
        chk_reset_outputs("midrst");
        i_rst = 1'b0;
        repeat (10) tick();
        chk_val("held_step_position", o_position, 0);
        i_drv_step = 1'b0;
        repeat (5) tick();
        pulse(4, 16, 0, 0);
        chk_val("after_rst_position", o_position, 1);

        repeat (5) tick();
        chk_val("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/step_dir_monitor.md
# step_dir_monitor

Receiving end of the stepper-drive interface: it consumes the `drv_step` / `drv_dir` / `drv_enable_SM` stream that the pulse generator drives toward the motor driver. It tracks signed motor position and measures the step period in clocks, in the same units as the period word `N`. It also flags protocol violations: overspeed, short pulses and direction-setup failures. It sits beside the driver pins and feeds closed-loop checking and status registers.

## Interface
- `POS_W`, 32, width of the signed position counter
- `PER_W`, 17, width of the period measurement; matches `N`
- `MIN_PERIOD`, 16, minimum legal clocks between step rising edges
- `MIN_HIGH`, 2, minimum legal clocks of `drv_step` high
- `DIR_SETUP`, 2, minimum clocks `drv_dir` must be stable before a step rising edge
- `TIMEOUT`, 2^PER_W-1, clocks without a step edge before the block declares a stall

Ports:
- `clk` in 1: single clock domain; one clock, used for everything
- `rst` in 1: synchronous, active-high reset
- `drv_step` in 1: step pulse; asynchronous to `clk`
- `drv_dir` in 1: direction; 1 = +1 per step, 0 = -1 per step
- `drv_enable_SM` in 1: driver enable
- `pos_clr` in 1: one-cycle pulse that zeroes the position
- `err_clr` in 1: one-cycle pulse that clears the sticky error flags
- `position` out POS_W: signed step count, two's complement, wraps at the limits
- `period` out PER_W: last measured step period, in clocks
- `period_vld` out 1: `period` is current
- `step_seen` out 1: one-cycle pulse per accepted step edge
- `stalled` out 1: high while in STALL
- `err_overspeed`, `err_width`, `err_dir` out 1 each: sticky error flags

## Operation
- `drv_step` and `drv_dir` each pass through a 2-flop synchronizer (s1, s2) followed by a history flop s3.
- Step edge = s2 & ~s3.
- State machine, four states:
  - IDLE: `drv_enable_SM` = 0. Edges are ignored, the period counter is held at 0, and `position` is held.
  - FIRST: enabled, but no reference edge yet. On an edge: count the position, restart the period counter, go to RUN. No period update.
  - RUN: on an edge: `period` <= period counter value, `period_vld` <= 1, count the position, restart the counter.
  - STALL: entered when the counter reaches TIMEOUT. On entry `period_vld` <= 0. An edge behaves as in FIRST.
- `drv_enable_SM` = 0 forces IDLE from any state; `period_vld` <= 0.
- Leaving IDLE (enable = 1) goes to FIRST.
- Period counter:
  - Reloads to 1 on the cycle after an edge.
  - Otherwise increments, saturating at 2^PER_W-1.
- Overspeed: a measured period < MIN_PERIOD sets `err_overspeed`.
- Width check: a high run of synced step shorter than MIN_HIGH, observed at its synced falling edge, sets `err_width`. Checked in all states except IDLE.
- Direction setup: a counter measures clocks since the synced dir last changed, saturating at DIR_SETUP. A step edge seen with that counter < DIR_SETUP sets `err_dir`. The step is still counted, using the new dir.
- Position arithmetic: modulo 2^POS_W; no saturation.
- Simultaneous events:
  - `pos_clr` with an edge: `position` = 0 and the step is dropped from position; the period is still measured.
  - `err_clr` with a new error: the set wins.

## Timing
- Reset values:
  - `position` = 0, `period` = 0, `period_vld` = 0, `step_seen` = 0, `stalled` = 0, all error flags = 0.
  - State = IDLE; all synchronizer and history flops = 0.
- Latency: a `drv_step` rise first sampled at clock edge k gives `step_seen`, `position` and `period` updated after edge k+3.
- `drv_dir` has the same 2-flop delay, so dir/step alignment is preserved.
- `stalled` rises one cycle after the counter equals TIMEOUT.
- `stalled` falls on the cycle the next accepted edge is processed.
- A reset asserted mid-pulse returns everything to reset values on the next clock. A step still high after reset does not produce an edge until it goes low and rises again.

## Structure
- Shared package `tr_pkg` holds:
  - the state enum (IDLE, FIRST, RUN, STALL)
  - the `PER_W` = 17 constant shared with the pulse generator
  - default MIN_PERIOD and TIMEOUT values
- Natural sub-module: `sync_edge`, a 2-flop synchronizer plus history flop with rise/fall outputs. Instantiated for step and for dir.

## Test plan
- Enable = 1, dir = 1, steps with period 20 and high time 4, ten pulses → `position` = 10; `period` = 20 and `period_vld` = 1 from the 2nd edge; no errors.
- Dir = 0, 5 steps, then `pos_clr` coincident with the 6th edge → `position` = 0 after that edge; `period` still updated.
- Period 10 with MIN_PERIOD = 16 → `err_overspeed` set on the 2nd edge and stays set until `err_clr`. Set-and-clear in the same cycle → the flag stays 1.
- 1-clock-high step → `err_width` = 1, `position` still counted. Dir toggled 1 clock before the step rise → `err_dir` = 1.
- Stop stepping with TIMEOUT = 100 → `stalled` = 1 and `period_vld` = 0 at clock 101 after the last edge; the next edge clears `stalled` with no period update; the following edge gives a valid period.
- Drop `drv_enable_SM` mid-train, then pulse → `position` is unchanged and the state is IDLE. Assert `rst` mid-pulse → all outputs reset; a held-high step is not counted.
